// File: rtl/conway_pkg.sv
// -----------------------------------------------------------------------------
// conway_pkg
// Shared definitions for the frame-store read path: default geometry of the
// single-clock BRAM frame store, the sweep-state encoding used by
// bram_stream_reader, and a small helper for buffer occupancy arithmetic.
// -----------------------------------------------------------------------------
package conway_pkg;

    // Default frame-store geometry, shared with the bram block.
    localparam int CW_DATA_WIDTH = 8;
    localparam int CW_DEPTH      = 200;
    localparam int CW_ADDR_WIDTH = 8;

    // Sweep state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sweep_state_t;

    // Words that will occupy the output buffer once this cycle's pop and the
    // in-flight read have both settled. A pop is only possible with a non-empty
    // buffer, so the result never goes negative.
    function automatic logic [2:0] pending_after_pop(
        input logic [1:0] count,
        input logic       inflight,
        input logic       pop
    );
        return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/bram_stream_reader_fifo2.sv
// -----------------------------------------------------------------------------
// fifo2
// Two-entry synchronous FIFO with registered outputs. The head entry register
// drives dout directly, so dout is stable while the consumer stalls.
// Ports:
//   clk, resetn : system clock, asynchronous active-low reset
//   push, din   : write request and word
//   pop         : read request (removes the head entry)
//   dout        : head entry
//   count       : occupancy 0..2
// A push into a full FIFO without a simultaneous pop is dropped, and a pop
// from an empty FIFO is ignored; the reader's issue rule prevents both.
// -----------------------------------------------------------------------------
module fifo2
    import conway_pkg::*;
#(
    parameter int WIDTH = CW_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       count_r;
    logic [WIDTH-1:0] head_s;
    logic [WIDTH-1:0] tail_s;
    logic [1:0]       count_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign dout  = head_r;
    assign count = count_r;

    // Next-state computation for the two storage slots and the occupancy.
    always_comb begin
        head_s    = head_r;
        tail_s    = tail_r;
        count_s   = count_r;
        do_pop_s  = pop && (count_r != 2'd0);
        do_push_s = push && ((count_r != 2'd2) || do_pop_s);
        case (count_r)
            2'd0: begin
                if (do_push_s) begin
                    head_s  = din;
                    count_s = 2'd1;
                end else begin
                    count_s = count_r;
                end
            end
            2'd1: begin
                if (do_push_s && do_pop_s) begin
                    head_s = din;
                end else if (do_push_s) begin
                    tail_s  = din;
                    count_s = 2'd2;
                end else if (do_pop_s) begin
                    count_s = 2'd0;
                end else begin
                    count_s = count_r;
                end
            end
            2'd2: begin
                // The tail always moves up on a pop so order is preserved.
                if (do_push_s && do_pop_s) begin
                    head_s = tail_r;
                    tail_s = din;
                end else if (do_pop_s) begin
                    head_s  = tail_r;
                    count_s = 2'd1;
                end else begin
                    count_s = count_r;
                end
            end
            default: begin
                count_s = 2'd0;
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
            count_r <= 2'd0;
        end else begin
            head_r  <= head_s;
            tail_r  <= tail_s;
            count_r <= count_s;
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Read-side master for the single-clock BRAM frame store. A start pulse in
// IDLE sweeps addresses 0..DEPTH-1 through the one-cycle-latency read port and
// presents the words as a valid/ready stream. A 2-entry buffer absorbs the
// read latency: full rate under constant ready, no loss under backpressure.
// Ports:
//   clk, resetn              : system clock, asynchronous active-low reset
//   start                    : sweep request, honoured only in IDLE
//   busy, done               : sweep in progress / one-cycle completion pulse
//   read_addr, read_enable   : BRAM read request
//   read_data                : BRAM read word, valid the cycle after the request
//   m_data, m_valid, m_ready : output stream
//   m_last                   : marks the beat from address DEPTH-1
// -----------------------------------------------------------------------------
module bram_stream_reader
    import conway_pkg::*;
#(
    parameter int DATA_WIDTH = CW_DATA_WIDTH,
    parameter int DEPTH      = CW_DEPTH,
    parameter int ADDR_WIDTH = CW_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    sweep_state_t          state_r;
    sweep_state_t          next_state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  inflight_r;
    logic                  inflight_last_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  read_enable_s;
    logic                  pop_s;
    logic                  at_last_s;
    logic                  head_last_s;
    logic [2:0]            pending_s;
    logic [DATA_WIDTH:0]   fifo_din_s;
    logic [DATA_WIDTH:0]   fifo_dout_s;
    logic [1:0]            fifo_count_s;

    assign busy        = busy_r;
    assign done        = done_r;
    assign read_addr   = addr_r;
    assign read_enable = read_enable_s;

    assign m_valid     = (fifo_count_s != 2'd0);
    assign m_data      = fifo_dout_s[DATA_WIDTH-1:0];
    assign head_last_s = fifo_dout_s[DATA_WIDTH];
    // The head register keeps its last tag after it drains; qualify it so the
    // tag is only visible alongside a real beat.
    assign m_last      = m_valid && head_last_s;
    assign pop_s       = m_valid && m_ready;
    assign at_last_s   = (addr_r == LAST_ADDR);
    assign pending_s   = pending_after_pop(fifo_count_s, inflight_r, pop_s);

    // The returning read word carries the last-address tag into the buffer.
    assign fifo_din_s  = {inflight_last_r, read_data};

    fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo2 (
        .clk    (clk),
        .resetn (resetn),
        .push   (inflight_r),
        .pop    (pop_s),
        .din    (fifo_din_s),
        .dout   (fifo_dout_s),
        .count  (fifo_count_s)
    );

    // Sweep FSM next state and read issue decision.
    always_comb begin
        next_state_s  = state_r;
        read_enable_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Issue only if the word will still fit once everything already
                // owed to the buffer has landed.
                read_enable_s = (pending_s < 3'd2);
                if (read_enable_s && at_last_s) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_last_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Sweep state register and status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (state_r == ST_DRAIN) && pop_s && head_last_s;
        end
    end

    // Read address counter; parked at zero while idle so a new sweep starts at 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (state_r == ST_IDLE) begin
            addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (read_enable_s && !at_last_s) begin
            addr_r <= addr_r + ADDR_WIDTH'(1);
        end else begin
            addr_r <= addr_r;
        end
    end

    // In-flight read tracking: the word requested this cycle returns next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= read_enable_s;
            inflight_last_r <= read_enable_s && at_last_s;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
// Drives sweeps of a DEPTH=200 reader with several ready patterns, a restart
// attempt, a mid-sweep reset, and a DEPTH=1 reader. Expected beats are queued
// from the memory image when a sweep starts; a negedge monitor pops and
// compares on every transfer.
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 200;
    localparam int AW    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] read_addr;
    logic          read_enable;
    logic [DW-1:0] read_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    logic          start1;
    logic          busy1;
    logic          done1;
    logic [0:0]    read_addr1;
    logic          read_enable1;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] m_data1;
    logic          m_valid1;
    logic          m_ready1;
    logic          m_last1;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem1_word;

    bram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .read_addr(read_addr), .read_enable(read_enable), .read_data(read_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    bram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(1), .ADDR_WIDTH(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .busy(busy1), .done(done1),
        .read_addr(read_addr1), .read_enable(read_enable1), .read_data(read_data1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_last(m_last1)
    );

    // BRAM models: one cycle read latency; garbage when not enabled so that a
    // reader sampling at the wrong time is caught.
    always @(posedge clk) begin
        if (read_enable) read_data <= mem[read_addr];
        else             read_data <= DW'($urandom);
        if (read_enable1) read_data1 <= mem1_word;
        else              read_data1 <= DW'($urandom);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Scoreboard and monitor state.
    logic [DW:0] exp_q [$];
    int issued = 0;
    int sweep_beats = 0;
    int done_cnt = 0;
    int first_valid_cyc = -1;
    int first_xfer_cyc = 0;
    int last_xfer_cyc = 0;
    int occ;
    bit pop_b;
    logic [DW:0] exp_beat;

    always @(negedge clk) begin
        if (resetn) begin
            pop_b = m_valid && m_ready;
            if (read_enable) begin
                chk("read_addr_order", read_addr, issued);
                occ = issued - sweep_beats - int'(pop_b) + 1;
                chk("issue_occupancy_le2", occ <= 2, 1);
                issued++;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pop_b) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_beat = exp_q.pop_front();
                    chk("beat_last_data", {m_last, m_data}, exp_beat);
                end
                if (sweep_beats == 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                sweep_beats++;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last_xfer", cyc, last_xfer_cyc + 1);
                chk("busy_low_with_done", busy, 0);
            end
        end
    end

    function automatic bit ready_for(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return (i % 2) == 0;
            2:       return i >= 20;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // One sweep: mode selects the ready pattern; restart_beat re-pulses start
    // at that beat count; reset_beat asserts resetn at that beat count.
    task automatic sweep(input int mode, input int restart_beat, input int reset_beat);
        int d0;
        int s_cyc;
        bit aborted;
        aborted = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), mem[i]});
        issued = 0;
        sweep_beats = 0;
        first_valid_cyc = -1;
        d0 = done_cnt;
        start = 1'b1;
        s_cyc = cyc;
        m_ready = ready_for(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 1; i < 3000 && done_cnt == d0 && !aborted; i++) begin
            if (mode == 2 && i == 19) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data_held", m_data, mem[0]);
                chk("stall_reads_issued", issued, 2);
            end
            m_ready = ready_for(mode, i);
            start = (restart_beat >= 0 && sweep_beats == restart_beat);
            if (reset_beat >= 0 && sweep_beats == reset_beat) begin
                resetn = 1'b0;
                #1;
                chk("async_reset_outputs",
                    {busy, done, m_valid, m_last, read_enable, read_addr, m_data}, 0);
                exp_q.delete();
                aborted = 1'b1;
                #2 resetn = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            repeat (5) @(posedge clk);
            #1;
            chk("single_done", done_cnt - d0, 1);
            chk("beat_count", sweep_beats, DEPTH);
            chk("queue_drained", exp_q.size(), 0);
            chk("first_valid_latency", first_valid_cyc - s_cyc, 3);
            chk("busy_idle_after", busy, 0);
            if (mode == 0) chk("back_to_back", last_xfer_cyc - first_xfer_cyc, DEPTH - 1);
        end
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        m_ready = 1'b0;
        start1 = 1'b0;
        m_ready1 = 1'b0;
        mem1_word = 8'hA5;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        #1;
        chk("reset_state",
            {busy, done, m_valid, m_last, read_enable, read_addr, m_data}, 0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        sweep(0, -1, -1);   // full rate
        sweep(1, -1, -1);   // ready toggling
        sweep(2, -1, -1);   // 20-cycle stall after start
        sweep(0, 50, -1);   // start re-pulsed mid-sweep
        sweep(0, -1, 100);  // reset mid-sweep
        sweep(0, -1, -1);   // fresh sweep after reset
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        sweep(3, -1, -1);
        sweep(3, -1, -1);

        // DEPTH=1 reader
        m_ready1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int i = 0; i < 20 && !m_valid1; i++) begin
            @(posedge clk); #1;
        end
        chk("d1_valid", m_valid1, 1);
        chk("d1_data", m_data1, 8'hA5);
        chk("d1_last", m_last1, 1);
        @(posedge clk); #1;
        chk("d1_done", done1, 1);
        chk("d1_busy_low", busy1, 0);
        chk("d1_no_more_valid", m_valid1, 0);
        @(posedge clk); #1;
        chk("d1_done_one_cycle", done1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
